// File: rtl/mem_req_queue_if.sv
// rtl/mem_req_queue_if.sv - request, dcache and exception bundle for mem_req_queue
interface mem_req_queue_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  in_valid;
  logic                  in_allowin;
  logic                  in_op;
  logic [1:0]            in_size;
  logic [31:0]           in_addr;
  logic [DATA_W-1:0]     in_wdata;
  logic [TAG_W-1:0]      in_tag;
  logic                  flush;

  logic                  req_valid;
  logic                  req_op;
  logic [2:0]            req_size;
  logic [31:0]           req_addr;
  logic [DATA_W/8-1:0]   req_wstrb;
  logic [DATA_W-1:0]     req_wdata;
  logic [TAG_W-1:0]      req_tag;
  logic                  req_addr_ok;

  logic                  excp_valid;
  logic [31:0]           excp_addr;
  logic [TAG_W-1:0]      excp_tag;
  logic [CNT_W-1:0]      count;

  modport master (
    output in_valid, in_op, in_size, in_addr, in_wdata, in_tag, flush, req_addr_ok,
    input  in_allowin, req_valid, req_op, req_size, req_addr, req_wstrb, req_wdata,
           req_tag, excp_valid, excp_addr, excp_tag, count
  );

  modport slave (
    input  in_valid, in_op, in_size, in_addr, in_wdata, in_tag, flush, req_addr_ok,
    output in_allowin, req_valid, req_op, req_size, req_addr, req_wstrb, req_wdata,
           req_tag, excp_valid, excp_addr, excp_tag, count
  );
endinterface

// File: rtl/mem_req_queue.sv
// rtl/mem_req_queue.sv - load/store request queue with alignment check and byte-lane formatting
module mem_req_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 32
) (
  input  logic           clk,
  input  logic           reset,
  mem_req_queue_if.slave bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              excp_valid_q, excp_valid_d;
  logic [31:0]       excp_addr_q, excp_addr_d;
  logic [TAG_W-1:0]  excp_tag_q, excp_tag_d;

  // Entry storage is never reset; count/pointers alone define what is live.
  logic              ent_op_q    [DEPTH];
  logic [1:0]        ent_size_q  [DEPTH];
  logic [31:0]       ent_addr_q  [DEPTH];
  logic [BYTES-1:0]  ent_wstrb_q [DEPTH];
  logic [DATA_W-1:0] ent_wdata_q [DEPTH];
  logic [TAG_W-1:0]  ent_tag_q   [DEPTH];

  logic [BYTES-1:0]  ent_wstrb_d;
  logic [DATA_W-1:0] ent_wdata_d;

  logic              allowin;
  logic              accept;
  logic              misalign;
  logic              push;
  logic              pop;
  logic [OFF_W-1:0]  off;

  assign allowin = (count_q < CNT_W'(DEPTH));
  assign accept  = bus.in_valid && allowin && !bus.flush;
  assign push    = accept && !misalign;
  assign pop     = (count_q != '0) && bus.req_addr_ok;
  assign off     = bus.in_addr[OFF_W-1:0];

  // Alignment check; a dword can never be aligned on a 32-bit path.
  always_comb begin
    misalign = 1'b0;
    case (bus.in_size)
      2'd1:    misalign = bus.in_addr[0];
      2'd2:    misalign = (bus.in_addr[1:0] != 2'b00);
      2'd3:    misalign = (DATA_W == 32) || (bus.in_addr[2:0] != 3'b000);
      default: misalign = 1'b0;
    endcase
  end

  // Byte-lane strobe and replicated store data for the incoming request.
  always_comb begin
    ent_wstrb_d = '0;
    ent_wdata_d = bus.in_wdata;
    case (bus.in_size)
      2'd0: begin
        ent_wstrb_d = BYTES'(1) << off;
        ent_wdata_d = {BYTES{bus.in_wdata[7:0]}};
      end
      2'd1: begin
        ent_wstrb_d = BYTES'(3) << off;
        ent_wdata_d = {(DATA_W/16){bus.in_wdata[15:0]}};
      end
      2'd2: begin
        ent_wstrb_d = BYTES'(15) << off;
        ent_wdata_d = {(DATA_W/32){bus.in_wdata[31:0]}};
      end
      default: begin
        ent_wstrb_d = '1;
        ent_wdata_d = bus.in_wdata;
      end
    endcase
    if (!bus.in_op) begin
      ent_wstrb_d = '0;
    end
  end

  // Pointer, occupancy and exception next-state; flush wins over push/pop.
  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    excp_valid_d = accept && misalign;
    excp_addr_d  = excp_addr_q;
    excp_tag_d   = excp_tag_q;
    if (accept && misalign) begin
      excp_addr_d = bus.in_addr;
      excp_tag_d  = bus.in_tag;
    end
    if (bus.flush) begin
      head_d       = '0;
      tail_d       = '0;
      count_d      = '0;
      excp_valid_d = 1'b0;
    end else begin
      if (push) begin
        tail_d = tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (!push && pop) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      excp_valid_q <= 1'b0;
      excp_addr_q  <= '0;
      excp_tag_q   <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      excp_valid_q <= excp_valid_d;
      excp_addr_q  <= excp_addr_d;
      excp_tag_q   <= excp_tag_d;
    end
  end

  // Write an aligned accepted request into the tail entry.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      ent_op_q[tail_q]    <= bus.in_op;
      ent_size_q[tail_q]  <= bus.in_size;
      ent_addr_q[tail_q]  <= bus.in_addr;
      ent_wstrb_q[tail_q] <= ent_wstrb_d;
      ent_wdata_q[tail_q] <= ent_wdata_d;
      ent_tag_q[tail_q]   <= bus.in_tag;
    end
  end

  assign bus.in_allowin = allowin;
  assign bus.req_valid  = (count_q != '0);
  assign bus.req_op     = ent_op_q[head_q];
  assign bus.req_size   = {1'b0, ent_size_q[head_q]};
  assign bus.req_addr   = ent_addr_q[head_q];
  assign bus.req_wstrb  = ent_wstrb_q[head_q];
  assign bus.req_wdata  = ent_wdata_q[head_q];
  assign bus.req_tag    = ent_tag_q[head_q];
  assign bus.excp_valid = excp_valid_q;
  assign bus.excp_addr  = excp_addr_q;
  assign bus.excp_tag   = excp_tag_q;
  assign bus.count      = count_q;
endmodule
